// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, oversampling constants and the baud divider computation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    // Oversampling ticks per bit
    localparam int OVS_RATE = 16;

    localparam logic [3:0] TICK_S0   = 4'd7;
    localparam logic [3:0] TICK_S1   = 4'd8;
    localparam logic [3:0] TICK_S2   = 4'd9;
    localparam logic [3:0] TICK_LAST = 4'd15;

    function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
        return clk_freq / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: free-running divider with a restart input that realigns the tick phase.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int OVS      = OVS_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int DIV = (calc_div(CLK_FREQ, BAUD, OVS) < 2) ? 2 : calc_div(CLK_FREQ, BAUD, OVS);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 2-FF synchronizer, 3-sample majority vote, one-entry output buffer.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report mismatches on parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int OVS      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    input  logic       err_clr
);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t     state, next_state;
    logic       rx_p0, rx_s, rx_prev;
    logic       tick, restart;
    logic [3:0] tick_cnt;
    logic [2:0] bit_idx;
    logic       samp0, samp1;
    logic [7:0] shreg;
    logic       mid0, mid1, mid2, last;
    logic       bit_maj;
    logic       shift_en, bit_inc, complete;
`ifdef UART_RX_PARITY_EN
    logic       par_chk;
`endif

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .OVS      (OVS)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // Synchronizer stage; rx_prev feeds the start-edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_p0   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_p0   <= rx;
            rx_s    <= rx_p0;
            rx_prev <= rx_s;
        end
    end

    assign mid0    = tick && (tick_cnt == TICK_S0);
    assign mid1    = tick && (tick_cnt == TICK_S1);
    assign mid2    = tick && (tick_cnt == TICK_S2);
    assign last    = tick && (tick_cnt == TICK_LAST);
    assign bit_maj = maj3(samp0, samp1, rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        restart    = 1'b0;
        shift_en   = 1'b0;
        bit_inc    = 1'b0;
        complete   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                // A level-low line (break) never re-arms: only a true 1->0 transition starts a frame
                if (rx_prev && !rx_s) begin
                    next_state = ST_START;
                    restart    = 1'b1;
                end
            end
            ST_START: begin
                if (mid2 && bit_maj) begin
                    next_state = ST_IDLE;
                end else if (last) begin
                    next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                shift_en = mid2;
                if (last) begin
                    bit_inc = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        next_state = ST_PARITY;
`else
                        next_state = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                par_chk = mid2;
                if (last) begin
                    next_state = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Finish at mid-stop so a back-to-back start edge is not missed
                if (mid2) begin
                    complete   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
        end else if (restart) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            if (tick && state != ST_IDLE) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (bit_inc) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // Sample and shift datapath
    always_ff @(posedge clk) begin
        if (mid0) begin
            samp0 <= rx_s;
        end
        if (mid1) begin
            samp1 <= rx_s;
        end
        if (shift_en) begin
            shreg[bit_idx] <= bit_maj;
        end
    end

    // Output buffer stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= 8'h00;
            valid <= 1'b0;
        end else if (complete && (!valid || ready)) begin
            data  <= shreg;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= (complete && !bit_maj) || (frame_err && !err_clr);
            overrun   <= (complete && valid && !ready) || (overrun && !err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= (par_chk && (bit_maj != ^shreg)) || (parity_err && !err_clr);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and randomized frames against a one-entry buffer model.
module tb_uart_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OVS      = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OVS);
    localparam int BIT      = DIV * OVS;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS    = 11;
`else
    localparam int NBITS    = 10;
`endif
    // Start edge to valid: 2 sync flops + edge detect, then (NBITS-1) bits and 10 ticks into the stop bit
    localparam int LAT_MIN  = ((NBITS - 1) * OVS + 10) * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, overrun, parity_err;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .OVS      (OVS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rcvd[$];
    logic       valid_q = 1'b0;
    int         last_rise_cyc = 0;

    always @(negedge clk) begin
        if (valid && ready) rcvd.push_back(data);
        if (valid && !valid_q) last_rise_cyc = cyc;
        valid_q = valid;
    end

    // Reference model: bytes expected at the handshake, plus the buffer and sticky flags
    logic [7:0] exp_q[$];
    logic       m_full, m_frame, m_over, m_par;
    logic [7:0] m_data;

    function automatic void model_reset();
        m_full = 1'b0; m_data = 8'h00; m_frame = 1'b0; m_over = 1'b0; m_par = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_frame(input logic [7:0] b, input logic stop_bit, input logic par_ok);
        if (!stop_bit) m_frame = 1'b1;
        if (!par_ok) m_par = 1'b1;
        if (ready) exp_q.push_back(b);
        else if (!m_full) begin
            m_full = 1'b1;
            m_data = b;
        end else m_over = 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int bl, input logic stop_bit, input logic par_flip);
        rx = 1'b0;
        repeat (bl) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bl) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (bl) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (bl) @(negedge clk);
        rx = 1'b1;
        model_frame(b, stop_bit, !par_flip);
    endtask

    task automatic drain_check(input string tag);
        int n;
        n = 0;
        while (rcvd.size() < exp_q.size() && n < 4 * BIT) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_count"}, rcvd.size(), exp_q.size());
        while (exp_q.size() > 0 && rcvd.size() > 0)
            check({tag, "_byte"}, rcvd.pop_front(), exp_q.pop_front());
        exp_q.delete();
        rcvd.delete();
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_valid"}, valid, m_full);
        check({tag, "_frame_err"}, frame_err, m_frame);
        check({tag, "_overrun"}, overrun, m_over);
        check({tag, "_parity_err"}, parity_err, m_par);
        if (m_full) check({tag, "_data"}, data, m_data);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        m_frame = 1'b0; m_over = 1'b0; m_par = 1'b0;
    endtask

    initial begin
        int         start_cyc;
        int         lat;
        logic [7:0] b;
        int         bl;
        logic       sb;

        model_reset();
        repeat (5) @(negedge clk);
        check("rst_valid", valid, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        rst = 1'b0;
        ready = 1'b1;
        repeat (2 * BIT) @(negedge clk);

        // Back-to-back frames; latency measured on the second one
        start_cyc = cyc;
        send_frame(8'h55, BIT, 1'b1, 1'b0);
        send_frame(8'hA3, BIT, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        lat = last_rise_cyc - (start_cyc + NBITS * BIT);
        check("latency_window", 32'(lat >= LAT_MIN && lat <= LAT_MIN + 4), 32'd1);
        drain_check("b2b");
        check_flags("b2b");

        // Short low glitch must be rejected, next frame still received
        rx = 1'b0;
        repeat (BIT / 8) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        drain_check("glitch");
        check_flags("glitch");
        send_frame(8'h3C, BIT, 1'b1, 1'b0);
        drain_check("after_glitch");
        check_flags("after_glitch");

        // Stop bit low: byte delivered with frame_err, then cleared
        send_frame(8'h7E, BIT, 1'b0, 1'b0);
        drain_check("frame");
        check_flags("frame");
        pulse_err_clr();
        check_flags("frame_clr");

        // Overrun: buffer held full while a second byte arrives
        ready = 1'b0;
        repeat (BIT) @(negedge clk);
        send_frame(8'h11, BIT, 1'b1, 1'b0);
        send_frame(8'h22, BIT, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        drain_check("ovr_hold");
        check_flags("ovr_hold");
        ready = 1'b1;
        exp_q.push_back(m_data);
        m_full = 1'b0;
        repeat (3) @(negedge clk);
        drain_check("ovr_drain");
        check_flags("ovr_drain");
        pulse_err_clr();
        check_flags("ovr_clr");

        // Reset during bit 4 of 0xF0 aborts the frame
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        rcvd.delete();
        repeat (2 * BIT) @(negedge clk);
        drain_check("abort");
        check_flags("abort");
        send_frame(8'h0F, BIT, 1'b1, 1'b0);
        drain_check("after_abort");
        check_flags("after_abort");

        // Break: one 0x00 with frame_err, no re-trigger while the line stays low
        rx = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        model_frame(8'h00, 1'b0, 1'b1);
        drain_check("break");
        check_flags("break");
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        pulse_err_clr();
        send_frame(8'hC5, BIT, 1'b1, 1'b0);
        drain_check("after_break");
        check_flags("after_break");

        // Random bytes with +/-2% baud skew and occasional bad stop bits
        for (int k = 0; k < 8; k++) begin
            b  = 8'($urandom_range(0, 255));
            bl = BIT - 3 + int'($urandom_range(0, 6));
            sb = ($urandom_range(0, 3) != 0);
            send_frame(b, bl, sb, 1'b0);
            drain_check("rand");
            check_flags("rand");
            pulse_err_clr();
        end

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, BIT, 1'b1, 1'b1);
        drain_check("parity");
        check_flags("parity");
        pulse_err_clr();
        check_flags("parity_clr");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver, the receive-side counterpart of the temperature tracker's UART transmitter. It carries host commands into the design, e.g. enable or poll requests for the temperature stream. Serial input is sampled at 16x oversampling with a 2-FF synchronizer and 3-sample majority vote. Each received byte goes into a one-entry output buffer with a valid/ready handshake and error flags.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 115200, line rate in bits/s
OVS, 16, oversampling ticks per bit (fixed at 16; not user-tuned)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
data  output  8  received byte, LSB first on the line
valid  output  1  data holds an unconsumed byte
ready  input  1  consumer accepts data when valid && ready
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: byte completed while buffer still full
parity_err  output  1  sticky: parity mismatch (see Optional Feature)
err_clr  input  1  one-cycle pulse clears all sticky error flags

Behaviour:
- Reset (async assert, sync release): state=IDLE, data=8'h00, valid=0, all error flags 0, synchronizer flops=1, counters=0.
- Tick generator: DIV = CLK_FREQ/(BAUD*OVS), truncated; 54 at defaults. Free-running counter 0..DIV-1 emits a one-cycle tick at DIV-1. The counter is restarted when IDLE detects a falling edge, which aligns ticks to the start edge.
- rx passes through 2 FFs (rx_s). All decisions use rx_s.
- FSM states IDLE, START, DATA, STOP (plus PARITY when the option is compiled in).
  - IDLE: on rx_s 1->0, go to START with tick_cnt=0.
  - START: at tick_cnt 7,8,9 capture samples. At tick 9, majority=1 means a glitch: return to IDLE with no flag. Majority=0 continues. At tick 15, go to DATA with bit_idx=0.
  - DATA: at tick 9, the majority vote is shifted into shreg[bit_idx] (LSB first). At tick 15, bit_idx increments; after bit 7, go to STOP.
  - STOP: at tick 9, evaluate majority and complete the byte in the same cycle, then return to IDLE immediately. Do not wait for the end of the stop bit, so back-to-back frames are caught.
- Completion when the buffer is empty, or is being consumed in the same cycle (valid && ready): data<=shreg and valid<=1 next cycle. Stop=0 also sets frame_err and still delivers the byte.
- Completion when the buffer is full and not consumed: discard the new byte, keep the old data, set overrun.
- Handshake: valid falls the cycle after valid && ready unless a new byte loads in that same cycle. data is stable while valid=1.
- err_clr clears the sticky flags. If a set event coincides with err_clr, the set wins.
- Latency: valid rises 1 clk after the stop-bit mid-sample, about 9.5 bit periods after the start edge.
- A break condition (rx low indefinitely) yields 8'h00 with frame_err, then IDLE waits for rx_s to return high before re-arming the edge detect.
- Reset mid-frame aborts the frame with no output.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: the frame becomes 8E1. A PARITY state between DATA and STOP samples the parity bit at tick 9. If the bit differs from ^shreg, parity_err is set and the byte is still delivered.
- Undefined: frame is 8N1, the PARITY state is absent, and parity_err is tied 0.

Decomposition:
- Package uart_pkg holds: state enum, OVS=16, mid-sample tick constants 7/8/9, last-tick constant 15, and the DIV computation function.
- One sub-module, uart_baud_tick: divider plus restart input and tick output. It is shared with a future refactor of the transmitter.
- Majority vote stays inline.

Test Plan:
- Send 0x55, then 0xA3 back-to-back at 115200 (868 clk/bit) with ready=1 -> valid pulses twice, data=0x55 then 0xA3, no flags.
- Low glitch of 100 clk on idle rx -> no valid, FSM back in IDLE, then a following 0x3C is received correctly.
- Frame 0x7E with stop bit driven 0 -> valid=1, data=0x7E, frame_err=1; err_clr pulse -> frame_err=0.
- ready=0, send 0x11 then 0x22 -> data stays 0x11, overrun=1; ready=1 -> 0x11 consumed, valid drops.
- Assert rst at bit 4 of 0xF0, release, then send 0x0F -> only 0x0F delivered.
- UART_RX_PARITY_EN defined: 0x07 sent with parity bit 0 -> parity_err=1, data=0x07. Baud skew of ±2% -> correct bytes.
